// File: rtl/ascensor_pkg.sv
// Shared encodings for the elevator controller: FSM state codes, travel direction, state width.
package ascensor_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle     = 3'd0,
    StMoveUp   = 3'd1,
    StMoveDown = 3'd2,
    StDoorOpen = 3'd3,
    StHalt     = 3'd4
  } state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

endpackage

// File: rtl/ascensor_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module ascensor_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/ascensor_ctrl.sv
// Elevator controller: latches floor calls and serves them, preferring the last travel direction.
// Defining ASCENSOR_EMERGENCY_EN adds the emg_stop port and the HALT state.
module ascensor_ctrl
  import ascensor_pkg::*;
#(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned DOOR_CYCLES = 8,
  parameter int unsigned MOVE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ASCENSOR_EMERGENCY_EN
  input  logic                      emg_stop,
`endif
  input  logic [FLOORS-1:0]         call_req,
  output logic [$clog2(FLOORS)-1:0] floor_idx,
  output logic [StateW-1:0]         state,
  output logic [FLOORS-1:0]         pending,
  output logic                      moving_up,
  output logic                      moving_down,
  output logic                      door_open
);

  localparam int unsigned FloorW = $clog2(FLOORS);
  localparam int unsigned DoorW  = $clog2(DOOR_CYCLES + 1);
  localparam int unsigned MoveW  = $clog2(MOVE_CYCLES + 1);

  localparam logic [FloorW-1:0] FloorOne = FloorW'(1);
  // Timers count N-1 down to 0, so the exit edge is the N-th edge after entry.
  localparam logic [DoorW-1:0]  DoorLoad = DoorW'(DOOR_CYCLES - 1);
  localparam logic [MoveW-1:0]  MoveLoad = MoveW'(MOVE_CYCLES - 1);

  state_e              state_q, state_d, dispatch_st;
  dir_e                dir_q, dir_d;
  logic [FloorW-1:0]   floor_q, floor_d;
  logic [FLOORS-1:0]   pending_q, pending_d;
  logic [FLOORS-1:0]   call_mask, clr_mask;
  logic                above_any, below_any, beyond_up, beyond_dn;
  logic                door_load, door_done, door_restart;
  logic                move_load, move_done;
  logic                emg;

`ifdef ASCENSOR_EMERGENCY_EN
  assign emg = emg_stop;
`else
  assign emg = 1'b0;
`endif

  ascensor_timer #(
    .WIDTH(DoorW)
  ) u_door_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (door_load),
    .load_val(DoorLoad),
    .done    (door_done)
  );

  ascensor_timer #(
    .WIDTH(MoveW)
  ) u_move_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (move_load),
    .load_val(MoveLoad),
    .done    (move_done)
  );

  // Pending calls relative to the car, and strictly beyond the neighbouring floor.
  always_comb begin
    above_any = 1'b0;
    below_any = 1'b0;
    beyond_up = 1'b0;
    beyond_dn = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (i > int'(floor_q))     above_any |= pending_q[i];
      if (i < int'(floor_q))     below_any |= pending_q[i];
      if (i > int'(floor_q) + 1) beyond_up |= pending_q[i];
      if (i < int'(floor_q) - 1) beyond_dn |= pending_q[i];
    end
  end

  always_comb begin
    if (above_any && below_any) begin
      dispatch_st = (dir_q == DirUp) ? StMoveUp : StMoveDown;
    end else if (above_any) begin
      dispatch_st = StMoveUp;
    end else if (below_any) begin
      dispatch_st = StMoveDown;
    end else begin
      dispatch_st = StIdle;
    end
  end

  // Next-state process.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    door_restart = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = pending_q[floor_q] ? StDoorOpen : dispatch_st;
      end
      StDoorOpen: begin
        if (call_req[floor_q]) begin
          door_restart = 1'b1;
        end else if (door_done) begin
          state_d = dispatch_st;
        end
      end
      StMoveUp: begin
        if (move_done) begin
          floor_d = floor_q + FloorOne;
          if (pending_q[floor_d]) begin
            state_d = StDoorOpen;
          end else if (!beyond_up) begin
            state_d = StIdle;
          end
        end
      end
      StMoveDown: begin
        if (move_done) begin
          floor_d = floor_q - FloorOne;
          if (pending_q[floor_d]) begin
            state_d = StDoorOpen;
          end else if (!beyond_dn) begin
            state_d = StIdle;
          end
        end
      end
      // HALT with the stop released falls back to IDLE.
      default: begin
        state_d = StIdle;
      end
    endcase
    if (emg) begin
      state_d      = StHalt;
      floor_d      = floor_q;
      door_restart = 1'b0;
    end
  end

  // Timer loads, direction memory and call latching derived from the chosen transition.
  always_comb begin
    dir_d = dir_q;
    if (state_d == StMoveUp) begin
      dir_d = DirUp;
    end else if (state_d == StMoveDown) begin
      dir_d = DirDown;
    end
    move_load = ((state_d == StMoveUp) || (state_d == StMoveDown)) &&
                ((state_d != state_q) || move_done);
    door_load = (state_d == StDoorOpen) && ((state_q != StDoorOpen) || door_restart);
    clr_mask  = '0;
    call_mask = '0;
    if ((state_d == StDoorOpen) && (state_q != StDoorOpen)) begin
      clr_mask[floor_d] = 1'b1;
    end
    if (door_restart) begin
      call_mask[floor_q] = 1'b1;
    end
    pending_d = (pending_q | (call_req & ~call_mask)) & ~clr_mask;
  end

  // State register process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= DirUp;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
    end
  end

  // Output process.
  always_comb begin
    state       = state_q;
    floor_idx   = floor_q;
    pending     = pending_q;
    moving_up   = (state_q == StMoveUp);
    moving_down = (state_q == StMoveDown);
    door_open   = (state_q == StDoorOpen);
  end

endmodule

// File: doc/ascensor_ctrl.md
ASCENSOR_CTRL -- requirements
Module: ascensor_ctrl

Interface
REQ-001 Parameter FLOORS, default 4: number of served floors, range 2..16.
REQ-002 Parameter DOOR_CYCLES, default 8: clock cycles the door stays open, at least 1.
REQ-003 Parameter MOVE_CYCLES, default 4: clock cycles to travel one floor, at least 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port call_req, input, FLOORS bits: one bit per floor; a high bit in any cycle registers a call for that floor.
REQ-007 Port floor_idx, output, $clog2(FLOORS) bits: current car floor.
REQ-008 Port state, output, 3 bits: current FSM state encoding.
REQ-009 Port pending, output, FLOORS bits: latched, not-yet-served calls.
REQ-010 Port moving_up, moving_down and door_open are outputs, 1 bit each, decoded from state.

Function
REQ-011 States SHALL be IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3 and HALT=4; HALT exists only with the macro in REQ-027.
REQ-012 pending SHALL update every edge as pending OR call_req, minus any bit cleared per REQ-015; FSM decisions SHALL use registered pending only, so there is 1 cycle of latching latency.
REQ-013 A last_dir register SHALL hold UP or DOWN, set on each entry to MOVE_UP or MOVE_DOWN.
REQ-014 In IDLE, next state SHALL be chosen in this priority order:
- pending[floor_idx] -> DOOR_OPEN;
- pending above and below both exist -> move in last_dir;
- only above -> MOVE_UP;
- only below -> MOVE_DOWN;
- none -> stay IDLE.
REQ-015 On entry to DOOR_OPEN, pending[floor_idx] SHALL clear at the same edge.
REQ-016 A call for floor_idx arriving while in DOOR_OPEN SHALL not be latched; it restarts the door timer to a full DOOR_CYCLES.
REQ-017 DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles, then follow the IDLE rule with pending[floor_idx] ignored; exit to IDLE only if no pending remains.
REQ-018 MOVE_x SHALL hold for MOVE_CYCLES cycles; on the final edge, floor_idx SHALL step by plus or minus 1, and next state SHALL be:
- DOOR_OPEN if pending[new floor];
- otherwise the same MOVE_x if pending lies strictly beyond in that direction;
- otherwise IDLE.
REQ-019 floor_idx SHALL never pass 0 or FLOORS-1; MOVE_UP SHALL never be entered at the top floor, nor MOVE_DOWN at floor 0.
REQ-020 door_open SHALL be high only in DOOR_OPEN; moving_up and moving_down SHALL be high only in their states and never simultaneously with door_open.
REQ-021 Simultaneous calls to several floors SHALL all latch in one cycle.

Reset
REQ-022 When rst is high at an edge, the block SHALL set state=IDLE, floor_idx=0, pending=0, last_dir=UP, timers=0, and all status outputs=0.
REQ-023 Reset mid-move or with the door open SHALL discard the partial travel and all pending calls; call_req in the reset cycle SHALL be ignored.

Configuration
REQ-024 Macro ASCENSOR_EMERGENCY_EN defined: input port emg_stop (1 bit) SHALL exist.
REQ-025 With ASCENSOR_EMERGENCY_EN, emg_stop high SHALL force HALT at the next edge from any state. In HALT:
- outputs are 0;
- floor_idx and pending are held;
- calls still latch.
REQ-026 With ASCENSOR_EMERGENCY_EN, emg_stop low in HALT SHALL return the FSM to IDLE at the next edge; interrupted travel restarts from floor_idx with a fresh MOVE_CYCLES count.
REQ-027 Macro ASCENSOR_EMERGENCY_EN undefined: there SHALL be no emg_stop port, HALT SHALL be unreachable, and the state encoding SHALL be unchanged.

Structure
REQ-028 Package ascensor_pkg SHALL hold the state encoding constants, the UP/DOWN direction constants and the state width (3).
REQ-029 Sub-module ascensor_timer SHALL be a loadable down-counter with a done flag, instantiated for both door and move timing.

Verification (FLOORS=4, DOOR_CYCLES=3, MOVE_CYCLES=2)
REQ-030 Reset test: hold rst for 2 cycles -> floor_idx=0, state=0, pending=4'b0000, door_open=0.
REQ-031 Same-floor call: call_req=4'b0001 for 1 cycle in IDLE at floor 0 (edge 0) ->
- pending=0001 at edge 1;
- DOOR_OPEN and pending=0000 at edge 2;
- IDLE at edge 5.
REQ-032 Long up-move: call_req=4'b1000 at edge 0 ->
- MOVE_UP at edge 2;
- floor_idx 1, 2, 3 at edges 4, 6, 8;
- DOOR_OPEN at edge 8;
- IDLE at edge 11.
REQ-033 Direction preference: at floor 1, IDLE, last_dir=UP, call_req=4'b0101 -> car serves floor 2 first, then floor 0; pending ends at 0000.
REQ-034 Reset mid-move: assert rst while floor_idx=1 in MOVE_UP with pending=1000 -> next edge gives floor_idx=0, IDLE, pending=0000.
REQ-035 ASCENSOR_EMERGENCY_EN build:
- emg_stop pulse for 4 cycles mid-move -> HALT with floor_idx held;
- on release -> IDLE, then travel resumes to the pending floor.
